// File: rtl/config_pkg.sv
// Shared types and constants for the host-to-FPGA UART packet protocol.
// Opcodes, header size, error codes and parser states.
package config_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;
    localparam logic [7:0] OP_DIV  = 8'hA2;

    localparam int unsigned HDR_BYTES = 4;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_OP  = 2'd1,
        ERR_BAD_LEN = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_OP,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_DRAIN
    } parser_state_e;

    function automatic logic op_known(input logic [7:0] op);
        logic known;
        known = 1'b0;
        unique case (1'b1)
            op == OP_ECHO,
            op == OP_ADD,
            op == OP_MUL,
            op == OP_DIV: known = 1'b1;
            default:      known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/uart_packet_parser.sv
// Byte-stream packet decoder: header parse, payload pass-through, drain of bad packets.
// Optional inter-byte gap timeout enabled by defining PARSER_TIMEOUT_EN.
module uart_packet_parser
    import config_pkg::*;
#(
    parameter logic [15:0] MaxLen        = 16'd1024,
    parameter logic [31:0] TimeoutCycles = 32'd100000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        hdr_valid_o,
    output logic [7:0]  opcode_o,
    output logic [15:0] length_o,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        data_last_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    parser_state_e state;
    logic [7:0]    op_q;
    logic [7:0]    len_lo_q;
    logic [15:0]   remaining;

    logic          in_payload;
    logic          accept;
    logic [15:0]   len_full;
    logic [15:0]   len_rem;
    logic          len_bad;
    logic          gap_hit;

    assign in_payload = (state == ST_PAYLOAD);
    assign accept     = rx_valid_i & rx_ready_o;
    assign len_full   = {rx_data_i, len_lo_q};
    assign len_rem    = len_full - 16'(HDR_BYTES);
    assign len_bad    = (len_full < 16'(HDR_BYTES)) || (len_full > MaxLen);

    // Payload is a zero-latency pass-through; every other state always accepts.
    always_comb begin
        rx_ready_o   = in_payload ? data_ready_i : 1'b1;
        data_valid_o = in_payload & rx_valid_i;
        data_o       = in_payload ? rx_data_i : 8'd0;
        data_last_o  = in_payload && (remaining == 16'd1);
    end

`ifdef PARSER_TIMEOUT_EN
    logic [31:0] gap_q;

    assign gap_hit = (state != ST_OP) && !rx_valid_i &&
                     ((gap_q + 32'd1) == TimeoutCycles);

    // Idle-cycle counter; stalls under backpressure do not count as idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gap_q <= '0;
        end else if (state == ST_OP || accept || gap_hit) begin
            gap_q <= '0;
        end else if (!rx_valid_i) begin
            gap_q <= gap_q + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
    assign gap_hit        = 1'b0;
`endif

    // Framing FSM with registered header/error pulses and held header fields.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_OP;
            op_q        <= '0;
            len_lo_q    <= '0;
            remaining   <= '0;
            hdr_valid_o <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
            opcode_o    <= '0;
            length_o    <= '0;
        end else begin
            hdr_valid_o <= 1'b0;
            err_o       <= 1'b0;
            if (gap_hit) begin
                err_o      <= 1'b1;
                err_code_o <= ERR_TIMEOUT;
                state      <= ST_OP;
            end else if (accept) begin
                unique case (state)
                    ST_OP: begin
                        op_q  <= rx_data_i;
                        state <= ST_RSVD;
                    end
                    ST_RSVD: begin
                        state <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        len_lo_q <= rx_data_i;
                        state    <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        remaining <= len_rem;
                        if (len_bad) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_BAD_LEN;
                            state      <= ST_OP;
                        end else if (!op_known(op_q)) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_BAD_OP;
                            state      <= (len_rem == 16'd0) ? ST_OP : ST_DRAIN;
                        end else begin
                            hdr_valid_o <= 1'b1;
                            opcode_o    <= op_q;
                            length_o    <= len_full;
                            state       <= (len_rem == 16'd0) ? ST_OP : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD,
                    ST_DRAIN: begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_OP;
                        end
                    end
                    default: begin
                        state <= ST_OP;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_packet_parser.md
# uart_packet_parser

Device-side decoder for the host-to-FPGA UART packet protocol. Sits between `uart_rx` byte output and the ALU/echo datapath. Consumes the raw byte stream (opcode, reserved, length LSB, length MSB, payload) and announces each header once. It streams payload bytes with a last flag and flags malformed packets. It keeps framing aligned so the next packet's opcode is always recognised.

## Interface
Parameters:
- `MaxLen`, 16'd1024: largest accepted total packet length in bytes, header included.
- `TimeoutCycles`, 32'd100000: inter-byte gap limit in clk_i cycles. Used only with the timeout feature.

Ports:
- `clk_i`, in, 1: single clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `rx_data_i`, in, 8: byte from uart_rx.
- `rx_valid_i`, in, 1: byte available.
- `rx_ready_o`, out, 1: byte accepted when `rx_valid_i & rx_ready_o`.
- `hdr_valid_o`, out, 1: one-cycle pulse when a complete, valid header has been parsed.
- `opcode_o`, out, 8: opcode of the current packet. Held until the next header.
- `length_o`, out, 16: total length of the current packet. Held until the next header.
- `data_o`, out, 8: payload byte.
- `data_valid_o`, out, 1: payload byte valid.
- `data_ready_i`, in, 1: downstream accepts payload byte.
- `data_last_o`, out, 1: qualifies the final payload byte.
- `err_o`, out, 1: one-cycle error pulse.
- `err_code_o`, out, 2: error code. 0 = none, 1 = BAD_OP, 2 = BAD_LEN, 3 = TIMEOUT. Held until the next error or reset.

## Operation
- FSM states are OP, RSVD, LEN_LO, LEN_HI, PAYLOAD and DRAIN. Reset state is OP.
- **OP:** latch the opcode.
- **RSVD:** accept any value and discard it.
- **LEN_LO, LEN_HI:** assemble the 16-bit little-endian length.
- **Header check** happens on LEN_HI acceptance, in this order:
  - Length < 4 or length > `MaxLen`: `err_o` with BAD_LEN, go to OP. The next byte is treated as an opcode.
  - Opcode not in {ECHO 8'hEC, ADD 8'hA0, MUL 8'hA1, DIV 8'hA2}: `err_o` with BAD_OP. If length == 4 go to OP, otherwise go to DRAIN.
  - Otherwise: pulse `hdr_valid_o` and update `opcode_o`/`length_o`. If length == 4, go to OP with no payload beats. Otherwise go to PAYLOAD.
- **Remaining counter:** 16-bit, loaded with length − 4. Decremented on each accepted payload or drain byte.
- **Leaving PAYLOAD/DRAIN:** go to OP on the byte accepted while remaining == 1.
- **PAYLOAD handshake:** combinational pass-through.
  - `data_o = rx_data_i`.
  - `data_valid_o = rx_valid_i`.
  - `rx_ready_o = data_ready_i`.
  - `data_last_o` = (remaining == 1).
- **Handshake rules:** `data_valid_o` must not depend on `data_ready_i`. Outside PAYLOAD, `data_valid_o` = 0.
- **rx_ready_o** = 1 in OP, RSVD, LEN_LO, LEN_HI and DRAIN.

## Timing
- **Reset values:** state OP, all outputs 0 except `rx_ready_o` = 1. `opcode_o`, `length_o` and `err_code_o` are 0.
- **Reset mid-packet:** the partial packet is discarded and the block returns to OP asynchronously.
- **hdr_valid_o / err_o:** registered. They assert the cycle after the LEN_HI byte is accepted.
- **Payload latency:** zero cycles. The first payload byte may be accepted in that same hdr_valid cycle.
- **Throughput:** one byte per cycle in every state.
- **Header-field update:** `opcode_o` and `length_o` change only in the `hdr_valid_o` cycle.

## Configuration
- **With `PARSER_TIMEOUT_EN` defined:**
  - A 32-bit gap counter clears on every accepted byte and in OP.
  - In any other state, it increments each cycle that `rx_valid_i` is low.
  - On reaching `TimeoutCycles`, assert `err_o` with TIMEOUT and go to OP.
  - Backpressure (`rx_valid_i` high, `data_ready_i` low) does not count.
- **Without `PARSER_TIMEOUT_EN`:**
  - No counter is present. Error code 3 is never produced.
  - The parser waits indefinitely mid-packet.

## Structure
- **Shared package `config_pkg`:**
  - Opcode localparams: `OP_ECHO`, `OP_ADD`, `OP_MUL`, `OP_DIV`.
  - `HDR_BYTES` = 4.
  - `err_code_e` enum.
  - `parser_state_e` enum.
- **Sub-modules:** none needed. The gap counter lives inline under the macro.

## Test plan
- **Echo packet:** send EC 00 0C 00, then 48 69 01 02 03 04 05 06 with `data_ready_i` = 1.
  - One `hdr_valid_o` with opcode EC and length 12.
  - 8 data beats in order, with `data_last_o` only on 06.
  - No `err_o`.
- **Backpressure:** same packet with `data_ready_i` toggling 1-of-3 cycles.
  - Identical byte sequence.
  - `rx_ready_o` mirrors `data_ready_i` during payload.
- **Header only:** send A0 00 04 00, then EC 00 05 00 7F.
  - First packet: `hdr_valid_o` with no data beats.
  - Second packet: header, then a single beat 7F with last.
- **Bad opcode:** send 55 00 06 00 AA BB, then EC 00 05 00 11.
  - BAD_OP error pulse.
  - AA and BB are drained with no `data_valid_o`.
  - The following echo packet parses normally.
- **Bad length:** send EC 00 02 00, then EC 00 05 00 22.
  - BAD_LEN error.
  - The next packet is parsed, with beat 22.
- **Timeout (`PARSER_TIMEOUT_EN`, `TimeoutCycles` = 50):** send EC 00, then idle 60 cycles.
  - TIMEOUT error at idle cycle 50.
  - A subsequent full packet parses normally.
